// File: rtl/tdm_demux_4.sv
// Four-slot TDM receiver: locks onto the sync marker, collects slots 0..2 in
// shadow lanes and publishes the full frame in one registered update on slot 3.
module tdm_demux_4 #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic               sync,
   input  logic [WIDTH-1:0]   din,
   output logic [4*WIDTH-1:0] dout,
   output logic               frame_valid,
   output logic [1:0]         slot,
   output logic               locked,
   output logic               sync_err,
   output logic [CNT_W-1:0]   frame_cnt
);

   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

   state_t                  state_q,  state_d;
   logic [1:0]              slot_q,   slot_d;
   // Slot 3 is never stored: it goes straight into dout with the shadow lanes.
   logic [2:0][WIDTH-1:0]   shadow_q, shadow_d;
   logic [4*WIDTH-1:0]      dout_q,   dout_d;
   logic                    fv_q,     fv_d;
   logic                    err_q,    err_d;
   logic [CNT_W-1:0]        cnt_q,    cnt_d;

   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      shadow_d = shadow_q;
      dout_d   = dout_q;
      cnt_d    = cnt_q;
      fv_d     = 1'b0;
      err_d    = 1'b0;
      if (in_valid) begin
         if (state_q == HUNT) begin
            if (sync) begin
               shadow_d[0] = din;
               slot_d      = 2'd1;
               state_d     = LOCKED;
            end
         end else if (sync) begin
            // A sync anywhere restarts the frame; off slot 0 it is an error.
            shadow_d[0] = din;
            slot_d      = 2'd1;
            err_d       = (slot_q != 2'd0);
         end else begin
            case (slot_q)
               2'd0: begin
                  err_d   = 1'b1;
                  state_d = HUNT;
               end
               2'd1: begin
                  shadow_d[1] = din;
                  slot_d      = 2'd2;
               end
               2'd2: begin
                  shadow_d[2] = din;
                  slot_d      = 2'd3;
               end
               default: begin
                  dout_d = {din, shadow_q[2], shadow_q[1], shadow_q[0]};
                  fv_d   = 1'b1;
                  cnt_d  = cnt_q + 1'b1;
                  slot_d = 2'd0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= HUNT;
         slot_q   <= '0;
         shadow_q <= '0;
         dout_q   <= '0;
         fv_q     <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         shadow_q <= shadow_d;
         dout_q   <= dout_d;
         fv_q     <= fv_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   assign dout        = dout_q;
   assign frame_valid = fv_q;
   assign slot        = slot_q;
   assign locked      = (state_q == LOCKED);
   assign sync_err    = err_q;
   assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_tdm_demux_4.sv
// Directed bench for tdm_demux_4 (WIDTH=4, CNT_W=2): framing, gaps, sync errors,
// counter wrap and asynchronous reset mid-frame.
module tb_tdm_demux_4;
   localparam int WIDTH = 4;
   localparam int CNT_W = 2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               sync;
   logic [WIDTH-1:0]   din;
   logic [4*WIDTH-1:0] dout;
   logic               frame_valid;
   logic [1:0]         slot;
   logic               locked;
   logic               sync_err;
   logic [CNT_W-1:0]   frame_cnt;

   int nvec = 0;
   int nerr = 0;

   tdm_demux_4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sync(sync), .din(din),
      .dout(dout), .frame_valid(frame_valid), .slot(slot), .locked(locked),
      .sync_err(sync_err), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Apply one cycle of input; return 1 time unit after the rising edge.
   task automatic cyc(input logic v, input logic s, input logic [WIDTH-1:0] d);
      in_valid = v;
      sync     = s;
      din      = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [15:0] e_dout, input logic e_fv,
                          input logic [1:0] e_slot, input logic e_lk, input logic e_err,
                          input logic [1:0] e_cnt);
      chk({tag, ".dout"},  32'(dout),        32'(e_dout));
      chk({tag, ".fv"},    32'(frame_valid), 32'(e_fv));
      chk({tag, ".slot"},  32'(slot),        32'(e_slot));
      chk({tag, ".lock"},  32'(locked),      32'(e_lk));
      chk({tag, ".err"},   32'(sync_err),    32'(e_err));
      chk({tag, ".cnt"},   32'(frame_cnt),   32'(e_cnt));
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; sync = 1'b0; din = '0;
      #3;
      chk_all("reset", 16'h0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic frame
      cyc(1, 1, 4'hA); chk_all("f1.s0", 16'h0, 0, 2'd1, 1, 0, 2'd0);
      cyc(1, 0, 4'h5); chk("f1.s1.slot", 32'(slot), 2);
      cyc(1, 0, 4'h3); chk("f1.s2.slot", 32'(slot), 3);
      chk("f1.s2.dout", 32'(dout), 0);
      cyc(1, 0, 4'hC); chk_all("f1.out", 16'hC35A, 1, 2'd0, 1, 0, 2'd1);
      cyc(0, 0, 4'h0); chk("f1.fv_drop", 32'(frame_valid), 0);

      // Same frame with gaps; sync during a gap must be ignored
      cyc(1, 1, 4'hA);
      cyc(0, 1, 4'hF); chk("gap1.slot", 32'(slot), 1); chk("gap1.lock", 32'(locked), 1);
      cyc(1, 0, 4'h5);
      cyc(0, 0, 4'h0);
      cyc(0, 1, 4'hE); chk("gap2.slot", 32'(slot), 2); chk("gap2.err", 32'(sync_err), 0);
      cyc(1, 0, 4'h3);
      for (int i = 0; i < 3; i++) cyc(0, 0, 4'h0);
      chk("gap3.slot", 32'(slot), 3); chk("gap3.fv", 32'(frame_valid), 0);
      cyc(1, 0, 4'hC); chk_all("f2.out", 16'hC35A, 1, 2'd0, 1, 0, 2'd2);

      // Early sync: restart on 7 and discard A,5
      cyc(1, 1, 4'hA);
      cyc(1, 0, 4'h5);
      cyc(1, 1, 4'h7); chk_all("early", 16'hC35A, 0, 2'd1, 1, 1, 2'd2);
      cyc(1, 0, 4'h1); chk("early.err_drop", 32'(sync_err), 0);
      cyc(1, 0, 4'h2); chk("early.fv_none", 32'(frame_valid), 0);
      cyc(1, 0, 4'h3); chk_all("f3.out", 16'h3217, 1, 2'd0, 1, 0, 2'd3);

      // Missing sync: drop to HUNT, ignore samples until sync
      cyc(1, 0, 4'h9); chk_all("miss", 16'h3217, 0, 2'd0, 0, 1, 2'd3);
      cyc(1, 0, 4'h1); chk("hunt.err", 32'(sync_err), 0); chk("hunt.lock", 32'(locked), 0);
      cyc(1, 0, 4'h2);
      cyc(1, 0, 4'h3);
      cyc(1, 0, 4'h4); chk_all("hunt.idle", 16'h3217, 0, 2'd0, 0, 0, 2'd3);
      cyc(1, 1, 4'h8); chk("relock", 32'(locked), 1);
      cyc(1, 0, 4'h6);
      cyc(1, 0, 4'h5);
      cyc(1, 0, 4'h4); chk_all("f4.wrap", 16'h4568, 1, 2'd0, 1, 0, 2'd0);

      // Back-to-back frame, then asynchronous reset mid-frame
      cyc(1, 1, 4'h1);
      cyc(1, 0, 4'h2);
      cyc(1, 0, 4'h3);
      cyc(1, 0, 4'h4); chk_all("f5.b2b", 16'h4321, 1, 2'd0, 1, 0, 2'd1);
      cyc(1, 1, 4'hD);
      cyc(1, 0, 4'hE);
      rst_n = 1'b0;
      #2;
      chk_all("midrst", 16'h0, 0, 2'd0, 0, 0, 2'd0);
      rst_n = 1'b1;
      cyc(1, 0, 4'h3); chk("post.lock", 32'(locked), 0);
      cyc(1, 0, 4'h4);
      cyc(1, 0, 4'h5); chk_all("post.idle", 16'h0, 0, 2'd0, 0, 0, 2'd0);
      cyc(1, 1, 4'h0);
      cyc(1, 0, 4'hF);
      cyc(1, 0, 4'h0);
      cyc(1, 0, 4'hF); chk_all("f6.out", 16'hF0F0, 1, 2'd0, 1, 0, 2'd1);
      cyc(0, 0, 4'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
